// File: rtl/block_integrator.sv
// Block integrator: sums a programmable number of samples per block and hands
// the result to a double-buffered output register so blocks stream without bubbles.
module block_integrator #(
    parameter int bW     = 8,
    parameter int sW     = 16,
    parameter int maxC   = 16,
    parameter int cW     = $clog2(maxC + 1),
    parameter int SIGNED = 0,
    parameter int SAT    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [cW-1:0] len,
    input  logic          flush,
    input  logic [bW-1:0] d,
    input  logic          d_vld,
    output logic          d_rdy,
    output logic [sW-1:0] sum,
    output logic [cW-1:0] sum_cnt,
    output logic          sum_ovf,
    output logic          sum_vld,
    input  logic          sum_rdy
);

    localparam bit            IS_SIGNED = (SIGNED != 0);
    localparam bit            IS_SAT    = (SAT != 0);
    localparam logic [cW-1:0] MAX_LEN   = cW'(maxC);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [sW-1:0] acc_q, acc_d;
    logic [cW-1:0] cnt_q, cnt_d;
    logic [cW-1:0] blen_q, blen_d;
    logic          ovf_q, ovf_d;
    logic [sW-1:0] sum_q, sum_d;
    logic [cW-1:0] sum_cnt_q, sum_cnt_d;
    logic          sum_ovf_q, sum_ovf_d;
    logic          sum_vld_q, sum_vld_d;

    logic [sW+bW-1:0] ext_wide;
    logic [sW-1:0]    ext_d;
    logic [sW:0]      add_raw;
    logic             add_ovf;
    logic [sW-1:0]    sat_val;
    logic [sW-1:0]    add_res;
    logic [cW-1:0]    len_eff;
    logic [cW-1:0]    blen_eff;
    logic [cW-1:0]    cnt_inc;
    logic             accept;
    logic             done;
    logic             out_free;
    logic [sW-1:0]    fin_acc;
    logic [cW-1:0]    fin_cnt;
    logic             fin_ovf;

    assign d_rdy = !rst && (state_q != WAIT);

    always_comb begin
        ext_wide = {{sW{IS_SIGNED & d[bW-1]}}, d};
        ext_d    = ext_wide[sW-1:0];
        add_raw  = {1'b0, acc_q} + {1'b0, ext_d};
        if (IS_SIGNED) begin
            // Signed overflow: operands agree in sign but the result does not.
            add_ovf = (acc_q[sW-1] == ext_d[sW-1]) && (add_raw[sW-1] != acc_q[sW-1]);
            sat_val = acc_q[sW-1] ? {1'b1, {(sW-1){1'b0}}} : {1'b0, {(sW-1){1'b1}}};
        end else begin
            add_ovf = add_raw[sW];
            sat_val = '1;
        end
        add_res = (add_ovf && IS_SAT) ? sat_val : add_raw[sW-1:0];
    end

    always_comb begin
        len_eff  = (len == '0) ? cW'(1) : ((len > MAX_LEN) ? MAX_LEN : len);
        blen_eff = (cnt_q == '0) ? len_eff : blen_q;
        cnt_inc  = cnt_q + cW'(1);
        accept   = d_vld && d_rdy;
        out_free = !sum_vld_q || sum_rdy;
        done     = (state_q != WAIT) &&
                   ((accept && (cnt_inc == blen_eff)) || (flush && ((cnt_q != '0) || accept)));
        fin_acc  = accept ? add_res : acc_q;
        fin_cnt  = accept ? cnt_inc : cnt_q;
        fin_ovf  = ovf_q | (accept & add_ovf);
    end

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        blen_d    = blen_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        sum_cnt_d = sum_cnt_q;
        sum_ovf_d = sum_ovf_q;
        sum_vld_d = sum_vld_q && !sum_rdy;

        if (accept && (cnt_q == '0)) begin
            blen_d = len_eff;
        end

        unique case (state_q)
            IDLE, ACC: begin
                if (done && out_free) begin
                    sum_d     = fin_acc;
                    sum_cnt_d = fin_cnt;
                    sum_ovf_d = fin_ovf;
                    sum_vld_d = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    state_d   = IDLE;
                end else if (done) begin
                    acc_d   = fin_acc;
                    cnt_d   = fin_cnt;
                    ovf_d   = fin_ovf;
                    state_d = WAIT;
                end else if (accept) begin
                    acc_d   = fin_acc;
                    cnt_d   = fin_cnt;
                    ovf_d   = fin_ovf;
                    state_d = ACC;
                end
            end
            WAIT: begin
                if (out_free) begin
                    sum_d     = acc_q;
                    sum_cnt_d = cnt_q;
                    sum_ovf_d = ovf_q;
                    sum_vld_d = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            blen_q    <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            sum_cnt_q <= '0;
            sum_ovf_q <= 1'b0;
            sum_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            blen_q    <= blen_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            sum_cnt_q <= sum_cnt_d;
            sum_ovf_q <= sum_ovf_d;
            sum_vld_q <= sum_vld_d;
        end
    end

    assign sum     = sum_q;
    assign sum_cnt = sum_cnt_q;
    assign sum_ovf = sum_ovf_q;
    assign sum_vld = sum_vld_q;

endmodule

// File: doc/block_integrator.md
Name: block_integrator

Overview:
Parametrised successor to the fixed 8-sample integrator. It accumulates a run-time-programmable number of input samples (1..maxC) into a block sum, with signed/unsigned and wrap/saturate modes, plus an early-terminate flush. The block sum is held in an output register while the next block accumulates, so the input runs at one sample per cycle with no bubble between blocks. It sits between a valid/ready sample source and a valid/ready sum consumer.

Parameters:
bW, 8, input sample width
sW, 16, sum width; must be >= bW
maxC, 16, maximum block length in samples
cW, $clog2(maxC+1), width of count and length fields
SIGNED, 0, 1 = d and sum are two's complement (sign-extend d); 0 = unsigned (zero-extend d)
SAT, 1, 1 = saturate sum at the sW range limits; 0 = wrap modulo 2^sW

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
len  in  cW  block length; sampled when the first sample of a block is accepted
flush  in  1  single-cycle request to end the current block early
d  in  bW  input sample
d_vld  in  1  d is valid
d_rdy  out  1  block is ready for d
sum  out  sW  block sum
sum_cnt  out  cW  number of samples contained in sum
sum_ovf  out  1  saturation or wrap occurred at least once in this block
sum_vld  out  1  sum, sum_cnt and sum_ovf are valid
sum_rdy  in  1  consumer is ready for sum

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, acc=0, cnt=0, blen=0, sum=0, sum_cnt=0, sum_ovf=0, sum_vld=0. d_rdy=0 while rst is high.
- Accept d when d_vld && d_rdy. Deliver the sum when sum_vld && sum_rdy.
- Output register is free in a cycle when (!sum_vld || sum_rdy).
- Length capture: the first accepted sample with cnt=0 latches blen=len. len=0 is treated as 1; len>maxC is clamped to maxC.
- States:
  - IDLE: cnt=0, d_rdy=1. An accepted sample moves the block to ACC, or completes it at once if blen=1.
  - ACC: d_rdy=1. Each accepted sample does acc=acc+ext(d) and cnt=cnt+1.
  - WAIT: block is complete but the output register is occupied. acc holds the result and d_rdy=0.
- Completion event: occurs in IDLE/ACC when either
  - the accepted sample makes cnt+1=blen, or
  - flush=1 and (cnt>0 or a sample is accepted that cycle).
  A sample accepted in the same cycle as flush is included in the block.
- On completion:
  - If the output register is free that cycle: next cycle sum=final acc, sum_cnt=final count, sum_ovf=block ovf flag, sum_vld=1. acc, cnt and the ovf flag clear; state=IDLE.
  - Otherwise: state=WAIT.
- WAIT: when the output register becomes free, the transfer happens at that edge and state=IDLE. flush is ignored in WAIT.
- flush with cnt=0 and no accepted sample is ignored. flush in IDLE with a simultaneous sample produces a 1-sample block.
- Latency: last sample accepted at edge t gives sum_vld=1 from t+1.
- Throughput: with sum_rdy held high, back-to-back blocks run with d_rdy=1 on every cycle.
- sum, sum_cnt and sum_ovf stay stable while sum_vld && !sum_rdy. sum_vld drops after the handshake unless a new transfer happens on the same edge.
- Arithmetic:
  - ext(d) is sign- or zero-extended to sW.
  - SAT=1: an overflowing addition clamps the result (unsigned to 2^sW-1; signed to 2^(sW-1)-1 or -2^(sW-1)) and sets the ovf flag.
  - SAT=0: the result wraps; the ovf flag is still set on carry-out (unsigned) or signed overflow.
  - The ovf flag is sticky until the block's result is transferred to the output register.
- rst mid-block discards the partial block and any pending output.

Test Plan:
- Unsigned, len=8, d=1..8 every cycle, sum_rdy=1 → sum=36, sum_cnt=8, sum_ovf=0. sum_vld is high 1 cycle after the 8th sample; the next block is accepted with no d_rdy gap.
- len=3, sum_rdy=0 after the first sum → second block fills, state=WAIT, d_rdy=0. Raising sum_rdy delivers the first sum, then the second sum on the next cycle.
- len=8, 3 samples of 5, then flush together with a 4th sample of 5 → sum=20, sum_cnt=4. Lone flush at cnt=0 gives no output.
- SAT=1, unsigned, sW=8, bW=8, len=4, d=100 ×4 → sum=255, sum_ovf=1. With SAT=0 → sum=144 (400 mod 256), sum_ovf=1.
- SIGNED=1, sW=8, len=2, d=-100,-100 → sum=-128 with SAT=1 (ovf=1), or 56 with SAT=0 (ovf=1). Also len=0 → 1-sample blocks; len=20 with maxC=16 → 16-sample blocks.
- rst asserted after 5 of 8 samples, with a sum pending → next cycle sum_vld=0, cnt=0. The next 8 samples produce a fresh correct sum.
